uart_rx: RTL and testbench

- 8N1 UART receiver for the board's uart_rxd pin, running in the clk108 domain.
- Oversamples the line at 16x baud, validates the start bit at mid-bit, shifts in 8 data bits LSB first and checks the stop bit.
- Hands each byte to the consumer through a one-entry valid/ready holding register.
- Counterpart to the transmit path that drives uart_txd.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_rx.sv | 138 +++++++++++++
 tb/tb_uart_rx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receive path (and the future transmit path).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  localparam int SAMPLES_PER_BIT = 16;
  localparam int MID_SAMPLE      = 7;
  localparam int DATA_BITS       = 8;

  // Clocks per 16x sample tick, rounded to nearest; 64-bit math avoids overflow at high clock rates.
  function automatic int calc_div(input int clk_hz, input int baud);
    return int'((longint'(clk_hz) + longint'(baud) * longint'(SAMPLES_PER_BIT / 2))
                / (longint'(baud) * longint'(SAMPLES_PER_BIT)));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running 16x oversample tick divider; clr parks the phase at zero so sampling aligns to an edge.
module uart_baud_tick #(
  parameter int DIV = 59
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clr && (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, mid-bit start validation, one-entry valid/ready output register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 108_000_000,
  parameter int BAUD   = 115200,
  parameter int DIV    = calc_div(CLK_HZ, BAUD)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic                 meta;
  logic                 rxd_s;
  logic                 tick;
  logic                 clr;
  rx_state_t            state;
  logic [3:0]           sub;
  logic [2:0]           idx;
  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      meta  <= rxd;
      rxd_s <= meta;
    end
  end

  assign clr = (state == ST_IDLE) || (state == ST_WAIT_HIGH);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sub       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A push in the same cycle below overrides this drain.
      if (valid && ready) begin
        valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (!rxd_s) begin
            state <= ST_START;
            sub   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            if (sub == 4'(MID_SAMPLE)) begin
              if (!rxd_s) begin
                state <= ST_DATA;
                sub   <= '0;
                idx   <= '0;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              sub <= sub + 4'd1;
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            sub <= sub + 4'd1;
            if (sub == 4'(SAMPLES_PER_BIT - 1)) begin
              shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
              idx   <= idx + 3'd1;
              if (idx == 3'(DATA_BITS - 1)) begin
                state <= ST_STOP;
              end
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            sub <= sub + 4'd1;
            if (sub == 4'(SAMPLES_PER_BIT - 1)) begin
              if (rxd_s) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                if (!valid || ready) begin
                  data  <= shreg;
                  valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                state     <= ST_WAIT_HIGH;
                frame_err <= 1'b1;
              end
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (rxd_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level reference model compared every cycle, plus directed literal checks.
module tb_uart_rx;

  localparam int BIT_CLK   = 160;                  // 18.432 MHz / 115200 baud
  localparam int LINE_LAT  = 3;                    // two sync flops plus the state register
  localparam int MID_LAT   = LINE_LAT + BIT_CLK / 2;
  localparam int STOP_LAT  = LINE_LAT + (19 * BIT_CLK) / 2;
  localparam int MAX_CYC   = 95000;
  localparam int MAX_PRINT = 30;

  typedef struct {
    int         at_edge;
    logic [7:0] b;
    bit         ok;
  } frame_ev_t;

  logic       clk;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLK_HZ(18_432_000),
    .BAUD  (115200)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rxd),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  bit         rand_ready = 0;

  frame_ev_t  fq[$];
  int         rise_q[$];
  int         fall_q[$];
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ferr = 1'b0;
  logic       exp_ovr = 1'b0;
  logic       exp_busy = 1'b0;

  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         got_q[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= MAX_PRINT)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : -1;
  endfunction

  task automatic clear_model();
    fq.delete();
    rise_q.delete();
    fall_q.delete();
    exp_data  = 8'h00;
    exp_valid = 1'b0;
    exp_ferr  = 1'b0;
    exp_ovr   = 1'b0;
    exp_busy  = 1'b0;
  endtask

  task automatic clear_counts();
    n_valid = 0;
    n_ferr  = 0;
    n_ovr   = 0;
    got_q.delete();
  endtask

  // Every stimulus step ends 1 time unit after a rising edge.
  task automatic tick_cycle();
    @(posedge clk);
    #1;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ok);
    int n;
    frame_ev_t ev;
    n = cyc;
    rxd = 1'b0;
    rise_q.push_back(n + LINE_LAT);
    ev.at_edge = n + STOP_LAT;
    ev.b = b;
    ev.ok = ok;
    fq.push_back(ev);
    if (ok) fall_q.push_back(n + STOP_LAT);
    repeat (BIT_CLK) tick_cycle();
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (BIT_CLK) tick_cycle();
    end
    rxd = ok;
    repeat (BIT_CLK) tick_cycle();
  endtask

  task automatic release_line();
    rxd = 1'b1;
    fall_q.push_back(cyc + LINE_LAT);
  endtask

  task automatic glitch(input int len);
    int n;
    n = cyc;
    rxd = 1'b0;
    rise_q.push_back(n + LINE_LAT);
    fall_q.push_back(n + MID_LAT);
    repeat (len) tick_cycle();
    rxd = 1'b1;
  endtask

  // Reference model: frame events resolve at their stop-sample edge, holding register follows handshake rules.
  initial begin : model_proc
    frame_ev_t ev;
    bit acc;
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc > MAX_CYC) begin
        $display("FAIL watchdog: cycle budget %0d exhausted", MAX_CYC);
        $fatal(1, "cycle budget exhausted");
      end
      if (rst_n) begin
        acc = exp_valid && (ready === 1'b1);
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        while (fq.size() != 0 && fq[0].at_edge < cyc) fq.delete(0);
        if (fq.size() != 0 && fq[0].at_edge == cyc) begin
          ev = fq.pop_front();
          if (!ev.ok) begin
            exp_ferr = 1'b1;
          end else if (!exp_valid || ready === 1'b1) begin
            exp_data  = ev.b;
            exp_valid = 1'b1;
          end else begin
            exp_ovr = 1'b1;
          end
        end else if (acc) begin
          exp_valid = 1'b0;
        end
        if (rise_q.size() != 0 && rise_q[0] == cyc) begin
          rise_q.delete(0);
          exp_busy = 1'b1;
        end
        if (fall_q.size() != 0 && fall_q[0] == cyc) begin
          fall_q.delete(0);
          exp_busy = 1'b0;
        end
      end
    end
  end

  initial begin : compare_proc
    forever begin
      @(negedge clk);
      check("data", int'(data), int'(exp_data));
      check("valid", int'(valid), int'(exp_valid));
      check("frame_err", int'(frame_err), int'(exp_ferr));
      check("overrun", int'(overrun), int'(exp_ovr));
      check("busy", int'(busy), int'(exp_busy));
      if (valid) n_valid++;
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (valid && ready) begin
        got_q.push_back(int'(data));
        $display("cycle %0d: byte %02h accepted", cyc, data);
      end
    end
  end

  initial begin : stim_proc
    int         kind;
    logic [7:0] b;
    rst_n = 1'b0;
    rxd   = 1'b1;
    ready = 1'b0;
    repeat (3) tick_cycle();
    check("reset_outputs", int'({data, valid, frame_err, overrun, busy}), 0);
    rst_n = 1'b1;
    repeat (10) tick_cycle();

    // 1: single byte, consumer always ready
    ready = 1'b1;
    clear_counts();
    send_frame(8'hA5, 1'b1);
    repeat (40) tick_cycle();
    check("t1_valid_cycles", n_valid, 1);
    check("t1_count", got_q.size(), 1);
    check("t1_byte", got_at(0), 'hA5);
    check("t1_flags", n_ferr + n_ovr, 0);
    check("t1_busy", int'(busy), 0);

    // 2: short low glitch is rejected at mid start bit
    clear_counts();
    glitch(40);
    repeat (80) tick_cycle();
    check("t2_busy", int'(busy), 0);
    check("t2_valid_cycles", n_valid, 0);
    check("t2_ferr", n_ferr, 0);

    // 3: bad stop then held break, then recovery
    clear_counts();
    send_frame(8'h3C, 1'b0);
    repeat (2000) tick_cycle();
    release_line();
    repeat (20) tick_cycle();
    send_frame(8'h55, 1'b1);
    repeat (40) tick_cycle();
    check("t3_ferr_pulses", n_ferr, 1);
    check("t3_count", got_q.size(), 1);
    check("t3_byte", got_at(0), 'h55);

    // 4: consumer stalled, second byte overruns
    ready = 1'b0;
    clear_counts();
    send_frame(8'h11, 1'b1);
    repeat (20) tick_cycle();
    send_frame(8'h22, 1'b1);
    repeat (40) tick_cycle();
    check("t4_valid", int'(valid), 1);
    check("t4_data", int'(data), 'h11);
    check("t4_overrun_pulses", n_ovr, 1);
    ready = 1'b1;
    tick_cycle();
    ready = 1'b0;
    tick_cycle();
    check("t4_valid_drop", int'(valid), 0);
    check("t4_data_hold", int'(data), 'h11);
    check("t4_accepted", got_at(0), 'h11);

    // 5: back-to-back frames
    ready = 1'b1;
    clear_counts();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    repeat (40) tick_cycle();
    check("t5_count", got_q.size(), 2);
    check("t5_first", got_at(0), 'h00);
    check("t5_second", got_at(1), 'hFF);
    check("t5_flags", n_ferr + n_ovr, 0);

    // 6: reset during bit 3 of 0x77
    clear_counts();
    b = 8'h77;
    rxd = 1'b0;
    rise_q.push_back(cyc + LINE_LAT);
    repeat (BIT_CLK) tick_cycle();
    for (int k = 0; k < 3; k++) begin
      rxd = b[k];
      repeat (BIT_CLK) tick_cycle();
    end
    rxd = b[3];
    repeat (BIT_CLK / 2) tick_cycle();
    rst_n = 1'b0;
    clear_model();
    #1;
    check("t6_reset_outputs", int'({data, valid, frame_err, overrun, busy}), 0);
    rxd = 1'b1;
    repeat (3) tick_cycle();
    rst_n = 1'b1;
    repeat (10) tick_cycle();
    send_frame(8'h5A, 1'b1);
    repeat (40) tick_cycle();
    check("t6_byte", got_at(0), 'h5A);
    check("t6_flags", n_ferr + n_ovr, 0);

    // Randomized traffic against the model with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      kind = $urandom_range(0, 9);
      b = 8'($urandom);
      if (kind == 0) begin
        glitch($urandom_range(1, 60));
        repeat (100) tick_cycle();
      end else if (kind == 1) begin
        send_frame(b, 1'b0);
        repeat ($urandom_range(10, 300)) tick_cycle();
        release_line();
        repeat ($urandom_range(10, 50)) tick_cycle();
      end else begin
        send_frame(b, 1'b1);
        if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 150)) tick_cycle();
      end
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    repeat (50) tick_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
